// File: rtl/go_encode.sv
// go_encode: sequential line-detection engine for the tic-tac-toe board.
//
// After a start pulse, the block reads the nine board cells over a read
// port and evaluates all eight lines. It then registers a 10-bit gameover
// vector for the win-line decoder on the display side.
//
// Ports:
//   clk       system clock
//   resetn    synchronous active-low reset
//   start     one-cycle pulse requesting evaluation of the current board
//   clear     synchronous new-game clear of the result (wins over start)
//   rd_addr   board cell address {row[1:0], col[1:0]}
//   rd_data   cell contents: 00 empty, 01 X, 10 O, 11 treated as empty
//   busy      high while a scan/evaluation is in flight, including the done cycle
//   done      one-cycle pulse; gameover updates in the same cycle
//   gameover  [7:0] line flags, [8] winner (0=X, 1=O), [9] game over
//
// Parameter:
//   RD_LATENCY  cycles from rd_addr to valid rd_data (1..3)
module go_encode #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [9:0] gameover
);

    // The scan counter runs from 0 in the first SCAN cycle. Addresses are
    // issued while cnt < 9, and the data for index n comes back at
    // cnt == n + RD_LATENCY. The last capture therefore happens at this
    // count.
    localparam int LAST_CNT = 8 + RD_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EVAL,
        DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [8:0] x_cells;
    logic [8:0] o_cells;
    logic       cap_valid;
    logic [3:0] cap_idx;
    logic [7:0] x_lines;
    logic [7:0] o_lines;
    logic [9:0] result;

    // Scan index n (row-major over the 3x3 board) to the sparse cell address.
    function automatic logic [3:0] scan_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 4'h0;
            4'd1:    return 4'h1;
            4'd2:    return 4'h2;
            4'd3:    return 4'h4;
            4'd4:    return 4'h5;
            4'd5:    return 4'h6;
            4'd6:    return 4'h8;
            4'd7:    return 4'h9;
            4'd8:    return 4'ha;
            default: return 4'h0;
        endcase
    endfunction

    // Line flags for one player's occupancy map. Bit order matches gameover[7:0].
    function automatic logic [7:0] line_hits(input logic [8:0] c);
        logic [7:0] h;
        h[0] = c[0] & c[1] & c[2];
        h[1] = c[3] & c[4] & c[5];
        h[2] = c[6] & c[7] & c[8];
        h[3] = c[0] & c[3] & c[6];
        h[4] = c[1] & c[4] & c[7];
        h[5] = c[2] & c[5] & c[8];
        h[6] = c[0] & c[4] & c[8];
        h[7] = c[2] & c[4] & c[6];
        return h;
    endfunction

    assign cap_valid = (state == SCAN) && (cnt >= 4'(RD_LATENCY));
    assign cap_idx   = cnt - 4'(RD_LATENCY);

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign rd_addr = ((state == SCAN) && (cnt < 4'd9)) ? scan_addr(cnt) : 4'h0;

    // X takes precedence when both players have lines, which can only
    // happen on an illegal board. Code 11 counts as neither player, so it
    // blocks a line and prevents a draw.
    always_comb begin
        x_lines = line_hits(x_cells);
        o_lines = line_hits(o_cells);
        result  = 10'h000;
        if (|x_lines) begin
            result = {2'b10, x_lines};
        end else if (|o_lines) begin
            result = {2'b11, o_lines};
        end else if (&(x_cells | o_cells)) begin
            result = 10'h200;
        end
    end

    // Next-state logic. clear overrides everything. A latched result
    // (gameover[9]) makes start a no-op until the next clear.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (start && !gameover[9]) next_state = SCAN;
                SCAN: if (cnt == 4'(LAST_CNT)) next_state = EVAL;
                EVAL: next_state = DONE;
                DONE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            x_cells  <= '0;
            o_cells  <= '0;
            gameover <= '0;
        end else begin
            state <= next_state;

            if ((state == SCAN) && !clear) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end

            if (cap_valid && !clear) begin
                x_cells[cap_idx] <= (rd_data == 2'b01);
                o_cells[cap_idx] <= (rd_data == 2'b10);
            end

            if (clear) begin
                gameover <= '0;
            end else if (state == EVAL) begin
                gameover <= result;
            end
        end
    end

endmodule

// File: doc/go_encode.md
Name: go_encode

Overview:
- Sequential line-detection engine for the tic-tac-toe board; produces the 10-bit gameover vector that the display-side win-line decoder consumes.
- After each move the game controller pulses start; the block scans the nine cells of board memory over a read port, evaluates all eight lines, and registers the result.
- Sits between the board RAM/register file and the VGA colour path.

Parameters:
- RD_LATENCY, 1, cycles from rd_addr presented to rd_data valid (legal range 1..3).

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse requesting evaluation of the current board
- clear  input  1  synchronous new-game clear of the result
- rd_addr  output  4  board cell address; cell = {row[1:0], col[1:0]}, legal rows/cols 0..2
- rd_data  input  2  cell contents: 00 empty, 01 X, 10 O, 11 treated as empty
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; gameover is updated in the same cycle
- gameover  output  10  result vector (encoding below)

Behaviour:
- Reset (resetn low at a clk edge): state IDLE; gameover=0, done=0, busy=0, rd_addr=0; the captured board clears to empty.
- gameover encoding:
  - bit0/1/2: rows 0/1/2 ({0,1,2}, {4,5,6}, {8,9,a}).
  - bit3/4/5: cols 0/1/2 ({0,4,8}, {1,5,9}, {2,6,a}).
  - bit6: diagonal {0,5,a}.
  - bit7: anti-diagonal {2,5,8}.
  - bit8: winner, 0=X, 1=O; 0 on a draw.
  - bit9: game over (win or draw).
- Line rule: a line is complete when all three cells equal 01, or all three equal 10.
- Win: bit9=1; bit8 and bits[7:0] set as follows.
  - Only X has complete lines: bits[7:0] flag X's lines; bit8=0.
  - Only O has complete lines: bits[7:0] flag O's lines; bit8=1.
  - Both players have complete lines (illegal board): report only X's lines, bit8=0.
  - Multiple lines for the winning player are all flagged.
- Draw: no complete line and all nine cells non-empty gives gameover=10'h200.
- No result: no complete line and at least one empty cell gives gameover=10'h000.
- FSM states: IDLE, SCAN, EVAL, DONE.
  - IDLE to SCAN: start=1, clear=0, gameover[9]=0.
  - SCAN to EVAL: after the last cell's data is captured.
  - EVAL to DONE: always, after one cycle.
  - DONE to IDLE: always, after one cycle.
- Timing, with start high in cycle 0:
  - rd_addr for scan index n (order 0,1,2,4,5,6,8,9,a) is driven in cycle 1+n, n=0..8.
  - rd_data for index n is sampled in cycle 1+n+RD_LATENCY.
  - EVAL is in cycle 10+RD_LATENCY.
  - done=1 and the new gameover are visible in cycle 11+RD_LATENCY (cycle 12 for the default).
  - busy=1 from cycle 1 through the done cycle inclusive.
- rd_addr returns to 0 outside SCAN. Addresses 3, 7 and b..f are never issued.
- start while busy: ignored.
- start while gameover[9]=1: ignored (sticky result); no scan and no done until clear.
- clear: takes priority over start in the same cycle. In any state it forces IDLE, gameover=0, busy=0, done=0, and discards a scan in progress; no done pulse is produced for the aborted scan.
- gameover holds its value between evaluations; it changes only at the done cycle, on clear, or on reset.
- resetn low mid-scan behaves as clear, and also empties the captured board.

Test Plan:
- Empty board, start pulse -> rd_addr sequence 0,1,2,4,5,6,8,9,a in cycles 1..9; done in cycle 12; gameover=10'h000; busy high in cycles 1..12.
- X at cells 0,1,2 and O at 4,5, start -> gameover=10'h201; a later start with the board unchanged is ignored (no busy, no done) until clear.
- O at 2,5,8 and O at 0,4 (anti-diagonal plus column 0 share cell 8; cells 0,4,8 all O) -> gameover=10'h388 (bits 9,8,7,3).
- Full board X O X / X O O / O X X, no line -> gameover=10'h200.
- clear asserted in cycle 5 of a scan, and start in the same cycle as clear -> no done, busy=0 next cycle, gameover=0, FSM in IDLE; a following start yields a normal scan.
- RD_LATENCY=3 with the board from the second scenario, plus rd_data=11 on cell 5 -> done in cycle 14; cell 5 is treated as empty; gameover=10'h201.
